// File: rtl/writeback_unit.sv
// Register-file writeback stage: merges single-cycle ALU results with a
// small FIFO of long-latency results, ALU first, r0 writes discarded.
module writeback_unit #(
   parameter int REG_COUNT  = 32,
   parameter int REG_W      = 32,
   parameter int REG_IDX_W  = $clog2(REG_COUNT),
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [REG_W-1:0]     alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [REG_W-1:0]     mem_data,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] wr_reg,
   output logic [REG_W-1:0]     wr_data,
   output logic                 alu_hold,
   input  logic [REG_IDX_W-1:0] pend_query,
   output logic                 pend_hit
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_MAX + 1);

   logic [REG_IDX_W-1:0] q_rd   [DEPTH];
   logic [REG_W-1:0]     q_data [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;
   logic [ST_W-1:0]      starve;

   logic                 alu_win;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 win_valid;
   logic [REG_IDX_W-1:0] win_rd;
   logic [REG_W-1:0]     win_data;
   logic [ST_W-1:0]      starve_next;

   // mem_ready depends on state only, so upstream may use it to form mem_valid
   assign mem_ready  = (count < CNT_W'(DEPTH));
   assign fifo_empty = (count == '0);
   assign alu_win    = alu_valid && (alu_rd != '0);
   assign push       = mem_valid && mem_ready && (mem_rd != '0);
   assign pop        = !alu_win && !fifo_empty;

   always_comb begin
      win_valid = 1'b0;
      win_rd    = '0;
      win_data  = '0;
      if (alu_win) begin
         win_valid = 1'b1;
         win_rd    = alu_rd;
         win_data  = alu_data;
      end else if (!fifo_empty) begin
         win_valid = 1'b1;
         win_rd    = q_rd[rd_ptr];
         win_data  = q_data[rd_ptr];
      end
   end

   // Starvation only accrues while a queued result is waiting behind the ALU
   always_comb begin
      starve_next = '0;
      if (!fifo_empty && alu_win) begin
         if (starve >= ST_W'(STARVE_MAX)) starve_next = ST_W'(STARVE_MAX);
         else                             starve_next = starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         starve   <= '0;
         wr_en    <= 1'b0;
         wr_reg   <= '0;
         wr_data  <= '0;
         alu_hold <= 1'b0;
      end else begin
         if (push) begin
            q_rd[wr_ptr]   <= mem_rd;
            q_data[wr_ptr] <= mem_data;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         wr_en <= win_valid;
         if (win_valid) begin
            wr_reg  <= win_rd;
            wr_data <= win_data;
         end
         starve   <= starve_next;
         alu_hold <= (starve_next >= ST_W'(STARVE_MAX));
      end
   end

   // Scan only the occupied slots, walking from the head
   always_comb begin
      pend_hit = 1'b0;
      if (pend_query != '0) begin
         if (wr_en && (wr_reg == pend_query)) pend_hit = 1'b1;
         for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (q_rd[rd_ptr + PTR_W'(k)] == pend_query))
               pend_hit = 1'b1;
         end
      end
   end

endmodule
